// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared player types, hitbox geometry, mover states and tile collision lookup
package utils;

    // 16.16 signed fixed-point pair (remainder, speed).
    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
    } vec2d;

    // Integer pixel position pair, 16-bit signed per axis.
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } vec2dint;

    // Player hitbox relative to the sprite origin; shared by the update block and the mover.
    localparam logic signed [15:0] HITBOX_X = 16'sd1;
    localparam logic signed [15:0] HITBOX_Y = 16'sd3;
    localparam logic signed [15:0] HITBOX_W = 16'sd6;
    localparam logic signed [15:0] HITBOX_H = 16'sd5;

    // Playfield extent in pixels; anything outside counts as solid.
    localparam logic signed [15:0] FIELD_W = 16'sd320;
    localparam logic signed [15:0] FIELD_H = 16'sd240;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        STEP_X,
        STEP_Y,
        DONE
    } mover_state_t;

    // Tile map lookup on 8x8 tiles: solid outside the field, and on every
    // tile whose column is 5 mod 8 and whose row is 2 mod 4.
    function automatic logic is_solid(input logic signed [15:0] px,
                                      input logic signed [15:0] py);
        if (px < 16'sd0 || py < 16'sd0 || px >= FIELD_W || py >= FIELD_H)
            return 1'b1;
        return (px[5:3] == 3'd5) && (py[4:3] == 2'd2);
    endfunction

    function automatic logic [15:0] abs16(input logic signed [15:0] v);
        return (v < 16'sd0) ? 16'(-v) : 16'(v);
    endfunction

endpackage

// File: rtl/mover_axis_calc.sv
// rtl/mover_axis_calc.sv - per-axis 16.16 step calculation: (rem, spd) -> (clamped steps, new remainder)
// Ports:
//   rem      in   32  sub-pixel remainder, 16.16 signed
//   spd      in   32  speed, 16.16 signed
//   steps    out  16  whole-pixel steps, clamped to +/-MAX_STEPS
//   rem_next out  32  remainder after removing the rounded pixel amount
module mover_axis_calc #(
    parameter int MAX_STEPS = 8
) (
    input  logic signed [31:0] rem,
    input  logic signed [31:0] spd,
    output logic signed [15:0] steps,
    output logic signed [31:0] rem_next
);

    localparam logic signed [31:0] LIM_POS = 32'(MAX_STEPS);
    localparam logic signed [31:0] LIM_NEG = -32'(MAX_STEPS);

    logic signed [31:0] sum;
    logic signed [31:0] amt;

    always_comb begin
        sum      = rem + spd;
        // Adding half a pixel before the arithmetic shift rounds half up.
        amt      = (sum + 32'sh0000_8000) >>> 16;
        // Remainder is taken from the unclamped amount; clamped-off pixels are lost.
        rem_next = sum - (amt <<< 16);
        if (amt > LIM_POS)
            steps = LIM_POS[15:0];
        else if (amt < LIM_NEG)
            steps = LIM_NEG[15:0];
        else
            steps = amt[15:0];
    end

endmodule

// File: rtl/player_mover.sv
// rtl/player_mover.sv - applies 16.16 speed to the player position one pixel per cycle with tile collision (option: PLAYER_MOVER_HIT_FLAGS_EN)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             move request, sampled only while idle
//   pos_i/rem_i/spd_i position, remainder and speed to move
//   busy              high while a move is in progress
//   done              one-cycle pulse when pos_o/rem_o/spd_o are updated
//   pos_o/rem_o/spd_o committed triple, held until the next done
//   hit_x/hit_y       per-axis collision flags (PLAYER_MOVER_HIT_FLAGS_EN only)
module player_mover
    import utils::*;
#(
    parameter int MAX_STEPS = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  vec2dint pos_i,
    input  vec2d    rem_i,
    input  vec2d    spd_i,
    output logic    busy,
    output logic    done,
    output vec2dint pos_o,
    output vec2d    rem_o,
    output vec2d    spd_o
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
    ,
    output logic    hit_x,
    output logic    hit_y
`endif
);

    mover_state_t       state;
    vec2dint            cur_pos;
    vec2d               cur_rem;
    vec2d               cur_spd;
    logic signed [15:0] steps_x_r;
    logic signed [15:0] steps_y_r;
    logic [15:0]        cnt;

    logic signed [15:0] calc_steps_x;
    logic signed [15:0] calc_steps_y;
    logic signed [31:0] calc_rem_x;
    logic signed [31:0] calc_rem_y;

    mover_axis_calc #(.MAX_STEPS(MAX_STEPS)) u_calc_x (
        .rem      (cur_rem.x),
        .spd      (cur_spd.x),
        .steps    (calc_steps_x),
        .rem_next (calc_rem_x)
    );

    mover_axis_calc #(.MAX_STEPS(MAX_STEPS)) u_calc_y (
        .rem      (cur_rem.y),
        .spd      (cur_spd.y),
        .steps    (calc_steps_y),
        .rem_next (calc_rem_y)
    );

    // Probe of the pixel just beyond the hitbox leading edge and the resulting
    // next-cycle values for whichever axis is stepping.
    logic               step_neg;
    logic signed [15:0] step_delta;
    logic signed [15:0] probe_x;
    logic signed [15:0] probe_y;
    logic               hit;
    logic               axis_end;
    vec2dint            nxt_pos;
    vec2d               nxt_rem;
    vec2d               nxt_spd;

    always_comb begin
        step_neg = 1'b0;
        probe_x  = cur_pos.x + HITBOX_X;
        probe_y  = cur_pos.y + HITBOX_Y;
        hit      = 1'b0;
        nxt_pos  = cur_pos;
        nxt_rem  = cur_rem;
        nxt_spd  = cur_spd;
        case (state)
            STEP_X: begin
                step_neg = steps_x_r[15];
                probe_x  = step_neg ? (cur_pos.x + HITBOX_X - 16'sd1)
                                    : (cur_pos.x + HITBOX_X + HITBOX_W);
                hit      = is_solid(probe_x, probe_y);
            end
            STEP_Y: begin
                step_neg = steps_y_r[15];
                probe_y  = step_neg ? (cur_pos.y + HITBOX_Y - 16'sd1)
                                    : (cur_pos.y + HITBOX_Y + HITBOX_H);
                hit      = is_solid(probe_x, probe_y);
            end
            default: ;
        endcase
        step_delta = step_neg ? -16'sd1 : 16'sd1;
        if (state == STEP_X) begin
            if (hit) begin
                nxt_spd.x = '0;
                nxt_rem.x = '0;
            end else begin
                nxt_pos.x = cur_pos.x + step_delta;
            end
        end else if (state == STEP_Y) begin
            if (hit) begin
                nxt_spd.y = '0;
                nxt_rem.y = '0;
            end else begin
                nxt_pos.y = cur_pos.y + step_delta;
            end
        end
        // A collision ends the axis immediately, regardless of remaining steps.
        axis_end = hit || (cnt == 16'd1);
    end

`ifdef PLAYER_MOVER_HIT_FLAGS_EN
    logic hit_x_q;
    logic hit_y_q;
    logic nxt_hit_x;
    logic nxt_hit_y;

    always_comb begin
        nxt_hit_x = hit_x_q | ((state == STEP_X) && hit);
        nxt_hit_y = hit_y_q | ((state == STEP_Y) && hit);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pos_o     <= '0;
            rem_o     <= '0;
            spd_o     <= '0;
            cur_pos   <= '0;
            cur_rem   <= '0;
            cur_spd   <= '0;
            steps_x_r <= '0;
            steps_y_r <= '0;
            cnt       <= '0;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
            hit_x_q   <= 1'b0;
            hit_y_q   <= 1'b0;
            hit_x     <= 1'b0;
            hit_y     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_pos <= pos_i;
                        cur_rem <= rem_i;
                        cur_spd <= spd_i;
                        busy    <= 1'b1;
                        state   <= CALC;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
                        hit_x_q <= 1'b0;
                        hit_y_q <= 1'b0;
`endif
                    end
                end

                CALC: begin
                    cur_rem.x <= calc_rem_x;
                    cur_rem.y <= calc_rem_y;
                    steps_x_r <= calc_steps_x;
                    steps_y_r <= calc_steps_y;
                    if (calc_steps_x != 16'sd0) begin
                        cnt   <= abs16(calc_steps_x);
                        state <= STEP_X;
                    end else if (calc_steps_y != 16'sd0) begin
                        cnt   <= abs16(calc_steps_y);
                        state <= STEP_Y;
                    end else begin
                        pos_o   <= cur_pos;
                        rem_o.x <= calc_rem_x;
                        rem_o.y <= calc_rem_y;
                        spd_o   <= cur_spd;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
                        hit_x   <= hit_x_q;
                        hit_y   <= hit_y_q;
`endif
                    end
                end

                STEP_X, STEP_Y: begin
                    cur_pos <= nxt_pos;
                    cur_rem <= nxt_rem;
                    cur_spd <= nxt_spd;
                    cnt     <= cnt - 16'd1;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
                    hit_x_q <= nxt_hit_x;
                    hit_y_q <= nxt_hit_y;
`endif
                    if (axis_end) begin
                        if (state == STEP_X && steps_y_r != 16'sd0) begin
                            cnt   <= abs16(steps_y_r);
                            state <= STEP_Y;
                        end else begin
                            pos_o <= nxt_pos;
                            rem_o <= nxt_rem;
                            spd_o <= nxt_spd;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
                            hit_x <= nxt_hit_x;
                            hit_y <= nxt_hit_y;
`endif
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// tb/tb_player_mover.sv - randomized and directed self-checking bench for player_mover
module tb_player_mover;
    import utils::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    start;
    vec2dint pos_i;
    vec2d    rem_i;
    vec2d    spd_i;
    logic    busy;
    logic    done;
    vec2dint pos_o;
    vec2d    rem_o;
    vec2d    spd_o;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
    logic    hit_x;
    logic    hit_y;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    player_mover #(.MAX_STEPS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pos_i (pos_i),
        .rem_i (rem_i),
        .spd_i (spd_i),
        .busy  (busy),
        .done  (done),
        .pos_o (pos_o),
        .rem_o (rem_o),
        .spd_o (spd_o)
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
        ,
        .hit_x (hit_x),
        .hit_y (hit_y)
`endif
    );

    always #5 clk = ~clk;

    localparam int ONE = 65536;

    // Reference tile map: 8x8 tiles on a 320x240 field, solid outside it and
    // where tile column mod 8 == 5 and tile row mod 4 == 2.
    function automatic bit ref_solid(input int px, input int py);
        if (px < 0 || py < 0 || px >= 320 || py >= 240) return 1'b1;
        return ((px / 8) % 8 == 5) && ((py / 8) % 4 == 2);
    endfunction

    // Pixel amount = rem+spd rounded half up, clamped to 8; remainder uses the unclamped amount.
    function automatic void ref_axis(input int rem, input int spd, output int steps, output int rem_n);
        int  s;
        real a;
        s     = rem + spd;
        a     = $floor((real'(s) + 32768.0) / 65536.0);
        rem_n = s - int'(a) * ONE;
        steps = int'(a);
        if (steps > 8) steps = 8;
        if (steps < -8) steps = -8;
    endfunction

    task automatic ref_move(input int x0, y0, rx, ry, sx, sy,
                            output int xo, yo, rxo, ryo, sxo, syo, probes,
                            output bit hx, hy);
        int stx, sty, dir;
        ref_axis(rx, sx, stx, rxo);
        ref_axis(ry, sy, sty, ryo);
        xo = x0; yo = y0; sxo = sx; syo = sy; probes = 0; hx = 0; hy = 0;
        dir = (stx < 0) ? -1 : 1;
        for (int i = 0; i < ((stx < 0) ? -stx : stx); i++) begin
            probes++;
            if (ref_solid((dir > 0) ? xo + 1 + 6 : xo + 1 - 1, yo + 3)) begin
                sxo = 0; rxo = 0; hx = 1;
                break;
            end
            xo += dir;
        end
        dir = (sty < 0) ? -1 : 1;
        for (int i = 0; i < ((sty < 0) ? -sty : sty); i++) begin
            probes++;
            if (ref_solid(xo + 1, (dir > 0) ? yo + 3 + 5 : yo + 3 - 1)) begin
                syo = 0; ryo = 0; hy = 1;
                break;
            end
            yo += dir;
        end
    endtask

    // Latency counts cycles from the start cycle to the done cycle.
    task automatic run_move(input int px, py, rx, ry, sx, sy, output int lat);
        @(posedge clk); #1;
        pos_i.x = 16'(px); pos_i.y = 16'(py);
        rem_i.x = rx; rem_i.y = ry;
        spd_i.x = sx; spd_i.y = sy;
        start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end while (!done && lat < 200);
    endtask

    task automatic settle();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        pos_i = '0; rem_i = '0; spd_i = '0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (pos_o !== '0 || rem_o !== '0 || spd_o !== '0)
            $display("FAIL reset_outputs: pos %h rem %h spd %h want 0", pos_o, rem_o, spd_o); else n_pass++;
        start = 1'b0; rst = 1'b0;
        settle();
    endtask

    task automatic test_open_space();
        int lat;
        vec2dint hold;
        run_move(40, 40, 0, 0, ONE + ONE / 2, 0, lat);
        n_checks++; if (done !== 1'b1 || lat != 4) $display("FAIL open_latency: got %0d want 4", lat); else n_pass++;
        n_checks++; if (rem_o.x !== 32'hFFFF8000) $display("FAIL open_rem_x: got %h want ffff8000", rem_o.x); else n_pass++;
        n_checks++; if (pos_o.x !== 16'sd42 || pos_o.y !== 16'sd40)
            $display("FAIL open_pos: got (%0d,%0d) want (42,40)", pos_o.x, pos_o.y); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL open_busy_at_done: got %b want 0", busy); else n_pass++;
        hold = pos_o;
        settle();
        n_checks++; if (done !== 1'b0 || pos_o !== hold)
            $display("FAIL open_hold: done %b pos %h want 0 and %h", done, pos_o, hold); else n_pass++;
    endtask

    task automatic test_wall_x();
        int lat;
        run_move(32, 16, 0, 0, 2 * ONE, 0, lat);
        n_checks++; if (pos_o.x !== 16'sd33) $display("FAIL wall_pos_x: got %0d want 33", pos_o.x); else n_pass++;
        n_checks++; if (spd_o.x !== 0 || rem_o.x !== 0)
            $display("FAIL wall_zeroed: spd %h rem %h want 0 0", spd_o.x, rem_o.x); else n_pass++;
        n_checks++; if (lat != 4) $display("FAIL wall_latency: got %0d want 4", lat); else n_pass++;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
        n_checks++; if (hit_x !== 1'b1 || hit_y !== 1'b0)
            $display("FAIL wall_hit: got %b%b want 10", hit_x, hit_y); else n_pass++;
`endif
        settle();
    endtask

    task automatic test_ceiling();
        int lat;
        run_move(39, 21, 0, 0, 0, -2 * ONE, lat);
        n_checks++; if (pos_o.y !== 16'sd21 || pos_o.x !== 16'sd39)
            $display("FAIL ceil_pos: got (%0d,%0d) want (39,21)", pos_o.x, pos_o.y); else n_pass++;
        n_checks++; if (spd_o.y !== 0 || rem_o.y !== 0 || spd_o.x !== 0 || rem_o.x !== 0)
            $display("FAIL ceil_vec: spd %h rem %h want 0", spd_o, rem_o); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL ceil_latency: got %0d want 3", lat); else n_pass++;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
        n_checks++; if (hit_x !== 1'b0 || hit_y !== 1'b1)
            $display("FAIL ceil_hit: got %b%b want 01", hit_x, hit_y); else n_pass++;
`endif
        settle();
    endtask

    task automatic test_saturate();
        int lat;
        run_move(100, 100, 0, 0, 20 * ONE, 0, lat);
        n_checks++; if (pos_o.x !== 16'sd108 || pos_o.y !== 16'sd100)
            $display("FAIL sat_pos: got (%0d,%0d) want (108,100)", pos_o.x, pos_o.y); else n_pass++;
        n_checks++; if (rem_o.x !== 0 || spd_o.x !== 20 * ONE)
            $display("FAIL sat_vec: rem %h spd %h want 0 %h", rem_o.x, spd_o.x, 20 * ONE); else n_pass++;
        n_checks++; if (lat != 10) $display("FAIL sat_latency: got %0d want 10", lat); else n_pass++;
        settle();
    endtask

    task automatic test_start_held();
        int nd, period, hold_cycles;
        pos_i.x = 16'sd40; pos_i.y = 16'sd40;
        rem_i = '0; spd_i.x = ONE + ONE / 2; spd_i.y = 0;
        hold_cycles = 12;
        period = 4 + 1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            start = (i < hold_cycles);
            @(posedge clk); #1;
            if (done) nd++;
        end
        start = 1'b0;
        n_checks++; if (nd != (hold_cycles + period - 1) / period)
            $display("FAIL held_done_count: got %0d want %0d", nd, (hold_cycles + period - 1) / period); else n_pass++;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            start = (i == 0 || i == 2);
            @(posedge clk); #1;
            if (done) nd++;
        end
        start = 1'b0;
        n_checks++; if (nd != 1) $display("FAIL busy_start_ignored: got %0d dones want 1", nd); else n_pass++;
        settle();
    endtask

    task automatic test_reset_mid_move();
        int nd;
        pos_i.x = 16'sd40; pos_i.y = 16'sd40;
        rem_i = '0; spd_i.x = 5 * ONE; spd_i.y = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_flags: busy %b done %b want 0 0", busy, done); else n_pass++;
        n_checks++; if (pos_o !== '0 || rem_o !== '0 || spd_o !== '0)
            $display("FAIL midrst_outputs: pos %h rem %h spd %h want 0", pos_o, rem_o, spd_o); else n_pass++;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        n_checks++; if (nd != 0) $display("FAIL midrst_no_done: got %0d dones want 0", nd); else n_pass++;
    endtask

    // Back-to-back randomized moves: each new start lands in the first idle cycle.
    task automatic test_back_to_back();
        int px, py, rx, ry, sx, sy, lat;
        int ex, ey, erx, ery, esx, esy, probes;
        bit hx, hy;
        for (int it = 0; it < 40; it++) begin
            px = $urandom_range(290, 16);
            py = $urandom_range(210, 16);
            rx = int'($urandom_range(131071, 0)) - ONE;
            ry = int'($urandom_range(131071, 0)) - ONE;
            sx = (it % 7 == 3) ? 0 : int'($urandom_range(24 * ONE, 0)) - 12 * ONE;
            sy = (it % 5 == 1) ? 0 : int'($urandom_range(24 * ONE, 0)) - 12 * ONE;
            ref_move(px, py, rx, ry, sx, sy, ex, ey, erx, ery, esx, esy, probes, hx, hy);
            run_move(px, py, rx, ry, sx, sy, lat);
            n_checks++; if (pos_o.x !== 16'(ex) || pos_o.y !== 16'(ey))
                $display("FAIL rnd%0d_pos: got (%0d,%0d) want (%0d,%0d)", it, pos_o.x, pos_o.y, ex, ey); else n_pass++;
            n_checks++; if (rem_o.x !== erx || rem_o.y !== ery)
                $display("FAIL rnd%0d_rem: got (%h,%h) want (%h,%h)", it, rem_o.x, rem_o.y, erx, ery); else n_pass++;
            n_checks++; if (spd_o.x !== esx || spd_o.y !== esy)
                $display("FAIL rnd%0d_spd: got (%h,%h) want (%h,%h)", it, spd_o.x, spd_o.y, esx, esy); else n_pass++;
            n_checks++; if (lat != 2 + probes)
                $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, 2 + probes); else n_pass++;
`ifdef PLAYER_MOVER_HIT_FLAGS_EN
            n_checks++; if (hit_x !== hx || hit_y !== hy)
                $display("FAIL rnd%0d_hit: got %b%b want %b%b", it, hit_x, hit_y, hx, hy); else n_pass++;
`endif
        end
        settle();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_open_space();
        test_wall_x();
        test_ceiling();
        test_saturate();
        test_start_held();
        test_back_to_back();
        test_reset_mid_move();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
